// File: rtl/vid_csc_pkg.sv
// Shared constants for the 4:2:2 YCbCr -> RGB pipeline: coefficient sets
// (CF = 8 fractional bits), configuration encodings and dither LFSR constants.
package vid_csc_pkg;

  localparam int CSC_CF = 8;
  localparam int COEF_W = 11;

  typedef enum logic {STD_601 = 1'b0, STD_709 = 1'b1} csc_std_e;
  typedef enum logic {RANGE_LIMITED = 1'b0, RANGE_FULL = 1'b1} csc_range_e;

  typedef struct packed {
    logic [COEF_W-1:0] ky;
    logic [COEF_W-1:0] krv;
    logic [COEF_W-1:0] kgu;
    logic [COEF_W-1:0] kgv;
    logic [COEF_W-1:0] kbu;
  } csc_coef_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Coefficient set selected by {full range, standard}.
  function automatic csc_coef_t csc_coef(input logic std, input logic full);
    case ({full, std})
      2'b01:   return '{ky: 11'd298, krv: 11'd459, kgu: 11'd55,  kgv: 11'd136, kbu: 11'd541};
      2'b10:   return '{ky: 11'd256, krv: 11'd359, kgu: 11'd88,  kgv: 11'd183, kbu: 11'd454};
      2'b11:   return '{ky: 11'd256, krv: 11'd403, kgu: 11'd48,  kgv: 11'd120, kbu: 11'd475};
      default: return '{ky: 11'd298, krv: 11'd409, kgu: 11'd100, kgv: 11'd208, kbu: 11'd516};
    endcase
  endfunction

  // Right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/vid_csc_sat.sv
// Per-component output stage: clamp a signed sum to [0, 2^IW-1], optionally
// add dither in the bits about to be dropped (re-clamped), then keep the OW MSBs.
module vid_csc_sat #(
  parameter int IW     = 8,
  parameter int OW     = 8,
  parameter int AW     = IW + 14,
  parameter bit DITHER = 1'b0
) (
  input  logic signed [AW-1:0] val,
  input  logic [IW-1:0]        dith,
  output logic [OW-1:0]        comp
);

  localparam logic [IW-1:0] MAXV = '1;
  localparam logic signed [AW-1:0] VMAX = AW'((1 << IW) - 1);
  localparam logic [IW-1:0] DMASK = DITHER ? IW'((1 << (IW - OW)) - 1) : '0;

  function automatic logic [IW-1:0] sat_clip(input logic signed [AW-1:0] v);
    if (v[AW-1]) return '0;
    if (v > VMAX) return MAXV;
    return v[IW-1:0];
  endfunction

  logic [IW-1:0] clip;
  logic [IW:0]   dsum;

  // Clamp, add masked dither, re-clamp on carry, truncate to OW bits.
  always_comb begin
    clip = sat_clip(val);
    dsum = {1'b0, clip} + {1'b0, dith & DMASK};
    comp = dsum[IW] ? MAXV[IW-1 -: OW] : dsum[IW-1 -: OW];
  end

endmodule

// File: rtl/vid_ycbcr422_rgb_pipe.sv
// 4:2:2 YCbCr -> RGB converter, one pixel per clock, fully stallable.
// Pipeline: pair holder (p0), offset removal (p1), products (p2),
// rounded sums (p3), saturate/truncate output register (p4).
// Optional dither: define VID_YCBCR2RGB_DITHER_EN (active only when OW < IW).
import vid_csc_pkg::*;

module vid_ycbcr422_rgb_pipe #(
  parameter int IW = 8,
  parameter int OW = 8,
  parameter int CF = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_std,
  input  logic          cfg_full,
  input  logic [IW-1:0] in_cb,
  input  logic [IW-1:0] in_y0,
  input  logic [IW-1:0] in_cr,
  input  logic [IW-1:0] in_y1,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] out_r,
  output logic [OW-1:0] out_g,
  output logic [OW-1:0] out_b,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int XW = IW + 1;
  localparam int PW = IW + 13;
  localparam int AW = IW + 14;
  localparam logic signed [XW-1:0] Y_OFS    = XW'(16 << (IW - 8));
  localparam logic signed [XW-1:0] C_OFS    = XW'(128 << (IW - 8));
  localparam logic signed [AW-1:0] RND_HALF = AW'(1 << (CF - 1));

  function automatic logic signed [PW-1:0] coef_mul(input logic signed [XW-1:0] a,
                                                    input logic [COEF_W-1:0] k);
    logic signed [PW-1:0] ax, kx;
    ax = PW'(a);
    kx = PW'($signed({1'b0, k}));
    return ax * kx;
  endfunction

  function automatic logic signed [AW-1:0] csc_round(input logic signed [AW-1:0] s);
    return (s + RND_HALF) >>> CF;
  endfunction

  logic adv, accept;
  logic vld_p0, phase_p0, vld_p1, vld_p2, vld_p3, vld_p4;
  logic [IW-1:0] cb_p0, cr_p0, y0_p0, y1_p0, y_sel;
  logic std_p0, full_p0, last_p0;
  logic signed [XW-1:0] yo_p1, cbo_p1, cro_p1;
  logic std_p1, full_p1, last_p1;
  csc_coef_t coef_s2;
  logic signed [PW-1:0] ky_p2, krv_p2, kgu_p2, kgv_p2, kbu_p2;
  logic last_p2;
  logic signed [AW-1:0] sum_r, sum_g, sum_b;
  logic signed [AW-1:0] r_p3, g_p3, b_p3;
  logic last_p3;
  logic [IW-1:0] dith_r, dith_g, dith_b;
  logic [OW-1:0] r_sat, g_sat, b_sat;

  assign adv       = ~vld_p4 | out_ready;
  assign in_ready  = rst_n & adv & (~vld_p0 | phase_p0);
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_p4;

  // Holder occupancy, pixel phase and per-stage valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      phase_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      vld_p4   <= 1'b0;
    end else if (adv) begin
      if (accept) begin
        vld_p0   <= 1'b1;
        phase_p0 <= 1'b0;
      end else if (vld_p0) begin
        vld_p0   <= ~phase_p0;
        phase_p0 <= ~phase_p0;
      end
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  // ---- p0: pair holder, config captured with the pair ----
  // Capture an accepted pair together with its configuration and line tag.
  always_ff @(posedge clk) begin
    if (accept) begin
      cb_p0   <= in_cb;
      cr_p0   <= in_cr;
      y0_p0   <= in_y0;
      y1_p0   <= in_y1;
      std_p0  <= cfg_std;
      full_p0 <= cfg_full;
      last_p0 <= in_last;
    end
  end

  assign y_sel   = phase_p0 ? y1_p0 : y0_p0;
  assign coef_s2 = csc_coef(std_p1, full_p1);

  always_comb begin
    sum_r = AW'(ky_p2) + AW'(krv_p2);
    sum_g = AW'(ky_p2) - AW'(kgu_p2) - AW'(kgv_p2);
    sum_b = AW'(ky_p2) + AW'(kbu_p2);
  end

  // Datapath stages p1..p3; contents only meaningful alongside their valid flag.
  always_ff @(posedge clk) begin
    if (adv) begin
      // ---- p1: remove black level / chroma bias ----
      yo_p1   <= full_p0 ? $signed({1'b0, y_sel}) : $signed({1'b0, y_sel}) - Y_OFS;
      cbo_p1  <= $signed({1'b0, cb_p0}) - C_OFS;
      cro_p1  <= $signed({1'b0, cr_p0}) - C_OFS;
      std_p1  <= std_p0;
      full_p1 <= full_p0;
      last_p1 <= last_p0 & phase_p0;
      // ---- p2: coefficient products ----
      ky_p2   <= coef_mul(yo_p1, coef_s2.ky);
      krv_p2  <= coef_mul(cro_p1, coef_s2.krv);
      kgu_p2  <= coef_mul(cbo_p1, coef_s2.kgu);
      kgv_p2  <= coef_mul(cro_p1, coef_s2.kgv);
      kbu_p2  <= coef_mul(cbo_p1, coef_s2.kbu);
      last_p2 <= last_p1;
      // ---- p3: rounded sums ----
      r_p3    <= csc_round(sum_r);
      g_p3    <= csc_round(sum_g);
      b_p3    <= csc_round(sum_b);
      last_p3 <= last_p2;
    end
  end

`ifdef VID_YCBCR2RGB_DITHER_EN
  localparam bit DITHER = (OW < IW);
  if (DITHER) begin : g_lfsr
    logic [15:0] lfsr_q;
    // Dither sequence steps once per pixel leaving p3.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else if (adv && vld_p3) lfsr_q <= lfsr_next(lfsr_q);
    end
    assign dith_r = IW'(lfsr_q);
    assign dith_g = IW'({lfsr_q, lfsr_q} >> 5);
    assign dith_b = IW'({lfsr_q, lfsr_q} >> 10);
  end else begin : g_no_lfsr
    assign dith_r = '0;
    assign dith_g = '0;
    assign dith_b = '0;
  end
`else
  localparam bit DITHER = 1'b0;
  assign dith_r = '0;
  assign dith_g = '0;
  assign dith_b = '0;
`endif

  vid_csc_sat #(.IW(IW), .OW(OW), .AW(AW), .DITHER(DITHER)) u_sat_r (
    .val(r_p3), .dith(dith_r), .comp(r_sat));
  vid_csc_sat #(.IW(IW), .OW(OW), .AW(AW), .DITHER(DITHER)) u_sat_g (
    .val(g_p3), .dith(dith_g), .comp(g_sat));
  vid_csc_sat #(.IW(IW), .OW(OW), .AW(AW), .DITHER(DITHER)) u_sat_b (
    .val(b_p3), .dith(dith_b), .comp(b_sat));

  // ---- p4: output register ----
  // Register the saturated pixel; cleared by reset so idle outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= '0;
      out_g    <= '0;
      out_b    <= '0;
      out_last <= 1'b0;
    end else if (adv) begin
      out_r    <= r_sat;
      out_g    <= g_sat;
      out_b    <= b_sat;
      out_last <= last_p3 & vld_p3;
    end
  end

endmodule

// File: tb/tb_vid_ycbcr422_rgb_pipe.sv
// Directed bench for vid_ycbcr422_rgb_pipe at IW = OW = 8 (default build).
module tb_vid_ycbcr422_rgb_pipe;

  localparam int IW = 8;
  localparam int OW = 8;

  typedef struct packed {
    logic [7:0] y0, y1, cb, cr;
    logic std, full, last;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n, cfg_std, cfg_full, in_last, in_valid, in_ready;
  logic [IW-1:0] in_cb, in_y0, in_cr, in_y1;
  logic [OW-1:0] out_r, out_g, out_b;
  logic out_last, out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  pair_t stim_q[$];

  always #5 clk = ~clk;

  vid_ycbcr422_rgb_pipe #(.IW(IW), .OW(OW), .CF(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_std(cfg_std), .cfg_full(cfg_full),
    .in_cb(in_cb), .in_y0(in_y0), .in_cr(in_cr), .in_y1(in_y1),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Reference conversion written from the coefficient table.
  function automatic logic [23:0] ref_pix(input logic [7:0] y, input logic [7:0] cb,
                                          input logic [7:0] cr, input logic std,
                                          input logic full);
    int k[5];
    int yo, cbo, cro, r, g, b;
    case ({full, std})
      2'b00:   k = '{298, 409, 100, 208, 516};
      2'b01:   k = '{298, 459, 55, 136, 541};
      2'b10:   k = '{256, 359, 88, 183, 454};
      default: k = '{256, 403, 48, 120, 475};
    endcase
    yo  = int'(y) - (full ? 0 : 16);
    cbo = int'(cb) - 128;
    cro = int'(cr) - 128;
    r = (k[0] * yo + k[1] * cro + 128) >>> 8;
    g = (k[0] * yo - k[2] * cbo - k[3] * cro + 128) >>> 8;
    b = (k[0] * yo + k[4] * cbo + 128) >>> 8;
    return {clamp8(r), clamp8(g), clamp8(b)};
  endfunction

  task automatic drive_pair(input pair_t p);
    in_y0 = p.y0; in_y1 = p.y1; in_cb = p.cb; in_cr = p.cr;
    cfg_std = p.std; cfg_full = p.full; in_last = p.last;
  endtask

  task automatic send_pair(input pair_t p);
    int n = 0;
    @(negedge clk);
    drive_pair(p);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_pix(input string tag, input logic last, input logic [23:0] rgb);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'({out_last, out_r, out_g, out_b}), 32'({last, rgb}));
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input string tag, input bit rnd, input int npairs);
    int idx = 0;
    int cyc = 0;
    logic [24:0] e;
    pair_t p;
    while ((idx < npairs || exp_q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      if (idx < npairs) begin
        p = stim_q[idx];
        drive_pair(p);
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_pixel"}, 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(tag, 32'({out_last, out_r, out_g, out_b}), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        if (rnd) begin
          exp_q.push_back({1'b0, ref_pix(p.y0, p.cb, p.cr, p.std, p.full)});
          exp_q.push_back({p.last, ref_pix(p.y1, p.cb, p.cr, p.std, p.full)});
        end
        idx++;
      end
      cyc++;
    end
    chk({tag, "_complete"}, 32'((idx == npairs) && (exp_q.size() == 0)), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pair_t p;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_std = 1'b0; cfg_full = 1'b0; in_last = 1'b0;
    in_cb = '0; in_y0 = '0; in_cr = '0; in_y1 = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'({out_last, out_r, out_g, out_b}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Black/white pair, latency 5 and 6 cycles from acceptance
    send_pair('{y0: 8'd16, y1: 8'd235, cb: 8'd128, cr: 8'd128, std: 1'b0, full: 1'b0, last: 1'b0});
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("latency_early", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("lat5_valid", 32'(out_valid), 32'd1);
    chk("lat5_pix0", 32'({out_last, out_r, out_g, out_b}), 32'h0000000);
    @(posedge clk); #1;
    chk("lat6_valid", 32'(out_valid), 32'd1);
    chk("lat6_pix1", 32'({out_last, out_r, out_g, out_b}), 32'h0FFFFFF);
    @(posedge clk); #1;
    chk("lat_idle", 32'(out_valid), 32'd0);

    // Saturation: R clips high, B clips low; second pixel shares the chroma
    send_pair('{y0: 8'd81, y1: 8'd0, cb: 8'd90, cr: 8'd240, std: 1'b0, full: 1'b0, last: 1'b1});
    expect_pix("sat_red", 1'b0, {8'd255, 8'd0, 8'd0});
    expect_pix("sat_y1", 1'b1, {8'd160, 8'd0, 8'd0});
    send_pair('{y0: 8'd0, y1: 8'd0, cb: 8'd128, cr: 8'd128, std: 1'b0, full: 1'b0, last: 1'b0});
    expect_pix("black_p0", 1'b0, 24'h000000);
    expect_pix("black_p1", 1'b0, 24'h000000);

    // BT.709 full range mid grey
    send_pair('{y0: 8'd128, y1: 8'd128, cb: 8'd128, cr: 8'd128, std: 1'b1, full: 1'b1, last: 1'b0});
    expect_pix("grey709_p0", 1'b0, {8'd128, 8'd128, 8'd128});
    expect_pix("grey709_p1", 1'b0, {8'd128, 8'd128, 8'd128});

    // Standard toggled on alternate back-to-back pairs
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      p = '{y0: 8'd100, y1: 8'd100, cb: 8'd60, cr: 8'd200, std: 1'(i % 2), full: 1'b0, last: (i == 3)};
      stim_q.push_back(p);
      if (i % 2 == 0) begin
        exp_q.push_back({1'b0, 8'd213, 8'd66, 8'd0});
        exp_q.push_back({1'b0, 8'd213, 8'd66, 8'd0});
      end else begin
        exp_q.push_back({1'b0, 8'd227, 8'd74, 8'd0});
        exp_q.push_back({(i == 3), 8'd227, 8'd74, 8'd0});
      end
    end
    run_stream("std_toggle", 1'b0, 4);

    // Random pairs with random source and sink gaps
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      p.y0 = 8'($urandom); p.y1 = 8'($urandom);
      p.cb = 8'($urandom); p.cr = 8'($urandom);
      p.std = 1'($urandom); p.full = 1'($urandom); p.last = 1'($urandom);
      stim_q.push_back(p);
    end
    run_stream("random", 1'b1, 64);

    // Peak throughput then a 3-cycle sink stall
    repeat (4) @(negedge clk);
    drive_pair('{y0: 8'd16, y1: 8'd235, cb: 8'd128, cr: 8'd128, std: 1'b0, full: 1'b0, last: 1'b0});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("tput_in_ready", 32'(in_ready), 32'(k % 2 == 0));
      if (k >= 5) begin
        chk("tput_out_valid", 32'(out_valid), 32'd1);
        chk("tput_pix", 32'({out_r, out_g, out_b}), ((k - 5) % 2 == 1) ? 32'h00FFFFFF : 32'h0);
      end
    end
    for (int k = 14; k < 17; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_pix", 32'({out_r, out_g, out_b}), 32'h00FFFFFF);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("stall_release_pix", 32'({out_r, out_g, out_b}), 32'h00FFFFFF);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("drained", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a busy stream
    drive_pair('{y0: 8'd100, y1: 8'd100, cb: 8'd60, cr: 8'd200, std: 1'b0, full: 1'b0, last: 1'b1});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); in_valid = 1'b1;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_data", 32'({out_last, out_r, out_g, out_b}), 32'd0);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    send_pair('{y0: 8'd16, y1: 8'd235, cb: 8'd128, cr: 8'd128, std: 1'b0, full: 1'b0, last: 1'b1});
    expect_pix("post_rst_p0", 1'b0, 24'h000000);
    expect_pix("post_rst_p1", 1'b1, 24'hFFFFFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
